// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: state encoding,
// operation codes and the default watchdog limit.
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } md_state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int unsigned TIMEOUT_DEFAULT = 40;

endpackage

// File: rtl/multdiv_ctrl_wait_counter.sv
// Watchdog counter for the WAIT state: synchronous clear, count enable and a
// terminal flag that is high while the count equals TIMEOUT.
module md_wait_counter
  import multdiv_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam logic [5:0] TERM_COUNT = 6'(TIMEOUT);

  logic [5:0] count;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 6'd1;
    end
  end

  assign term = (count == TERM_COUNT);

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer between execute and the shared multiplier/divider: latches one
// request, pulses the unit start, waits for RDY (or watchdog) and holds the result.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_op,
  input  logic [31:0] req_operandA,
  input  logic [31:0] req_operandB,
  input  logic [4:0]  req_rd,
  output logic        req_ready,
  output logic        busy,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  input  logic [31:0] mult_result,
  input  logic [31:0] div_result,
  input  logic        mult_exception,
  input  logic        div_exception,
  input  logic        mult_resultRDY,
  input  logic        div_resultRDY,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_result,
  output logic        wb_exception,
  output logic [4:0]  wb_rd
);

  md_state_e state, state_next;
  logic      op_q;
  logic      accept, div_zero, capture, timeout_hit, retire;
  logic      cnt_clr, cnt_en, cnt_term;
  logic      sel_rdy;

  md_wait_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_counter (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .term  (cnt_term)
  );

  // Only the unit that was started is listened to; the other may be stale.
  assign sel_rdy = (op_q == OP_DIV) ? div_resultRDY : mult_resultRDY;

  assign busy      = (state != ST_IDLE);
  assign req_ready = (state == ST_IDLE) && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    div_zero    = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    retire      = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if ((req_op == OP_DIV) && (req_operandB == '0)) begin
            div_zero   = 1'b1;
            state_next = ST_DONE;
          end else begin
            state_next = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: begin
        cnt_clr    = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // RDY takes priority over the watchdog in the same cycle.
        if (sel_rdy) begin
          capture    = 1'b1;
          state_next = ST_DONE;
        end else if (cnt_term) begin
          timeout_hit = 1'b1;
          state_next  = ST_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        if (wb_ready) begin
          retire     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_q         <= OP_MULT;
      md_operandA  <= '0;
      md_operandB  <= '0;
      ctrl_MULT    <= 1'b0;
      ctrl_DIV     <= 1'b0;
      wb_valid     <= 1'b0;
      wb_result    <= '0;
      wb_exception <= 1'b0;
      wb_rd        <= '0;
    end else begin
      ctrl_MULT <= accept && !div_zero && (req_op == OP_MULT);
      ctrl_DIV  <= accept && !div_zero && (req_op == OP_DIV);
      if (accept) begin
        op_q        <= req_op;
        md_operandA <= req_operandA;
        md_operandB <= req_operandB;
        wb_rd       <= req_rd;
      end
      if (div_zero || timeout_hit) begin
        wb_result    <= '0;
        wb_exception <= 1'b1;
        wb_valid     <= 1'b1;
      end else if (capture) begin
        wb_result    <= (op_q == OP_DIV) ? div_result : mult_result;
        wb_exception <= (op_q == OP_DIV) ? div_exception : mult_exception;
        wb_valid     <= 1'b1;
      end else if (retire) begin
        wb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: directed and random mult/div requests
// against a cycle-count and arithmetic reference, plus reset and handshake cases.
module tb_multdiv_ctrl;

  localparam int TIMEOUT = 40;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_op;
  logic [31:0] req_operandA;
  logic [31:0] req_operandB;
  logic [4:0]  req_rd;
  logic        req_ready;
  logic        busy;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] mult_result;
  logic [31:0] div_result;
  logic        mult_exception;
  logic        div_exception;
  logic        mult_resultRDY;
  logic        div_resultRDY;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_result;
  logic        wb_exception;
  logic [4:0]  wb_rd;

  int n_checks = 0;
  int n_err    = 0;

  multdiv_ctrl #(
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_op         (req_op),
    .req_operandA   (req_operandA),
    .req_operandB   (req_operandB),
    .req_rd         (req_rd),
    .req_ready      (req_ready),
    .busy           (busy),
    .md_operandA    (md_operandA),
    .md_operandB    (md_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .mult_result    (mult_result),
    .div_result     (div_result),
    .mult_exception (mult_exception),
    .div_exception  (div_exception),
    .mult_resultRDY (mult_resultRDY),
    .div_resultRDY  (div_resultRDY),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_result      (wb_result),
    .wb_exception   (wb_exception),
    .wb_rd          (wb_rd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[31:0];
  endfunction

  function automatic logic [31:0] div_ref(input logic [31:0] a, input logic [31:0] b);
    int q;
    q = $signed(a) / $signed(b);
    return q;
  endfunction

  // Unit model for one cycle: the started unit answers (stale RDY in cycle 1,
  // real RDY in rdy_cyc); the other unit babbles randomly.
  task automatic drive_units(input logic op, input int c, input int rdy_cyc,
                             input logic [31:0] res, input logic exc);
    logic        r;
    logic [31:0] v;
    logic        e;
    r = (c == 1) || (c == rdy_cyc);
    v = (c == rdy_cyc) ? res : $urandom;
    e = (c == rdy_cyc) ? exc : 1'($urandom);
    if (op) begin
      div_resultRDY  = r;  div_result  = v;  div_exception  = e;
      mult_resultRDY = 1'($urandom); mult_result = $urandom; mult_exception = 1'($urandom);
    end else begin
      mult_resultRDY = r;  mult_result = v;  mult_exception = e;
      div_resultRDY  = 1'($urandom); div_result = $urandom; div_exception = 1'($urandom);
    end
  endtask

  task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int rdy_cyc, input logic exc_in,
                       input int hold, input string nm);
    logic [31:0] unit_res, exp_res;
    logic        exp_exc;
    bit          div0;
    int          v;
    div0     = op && (b == 0);
    unit_res = op ? (div0 ? 32'd0 : div_ref(a, b)) : mul_ref(a, b);
    if (div0) begin
      v = 1; exp_res = '0; exp_exc = 1'b1;
    end else if (rdy_cyc >= 2 && rdy_cyc <= 2 + TIMEOUT) begin
      v = rdy_cyc + 1; exp_res = unit_res; exp_exc = exc_in;
    end else begin
      v = 3 + TIMEOUT; exp_res = '0; exp_exc = 1'b1;
    end

    for (int k = 0; k < 8 && !req_ready; k++) @(negedge clock);
    chk({nm, "_req_ready"}, req_ready, 1);
    chk({nm, "_idle_busy"}, busy, 0);
    req_valid = 1'b1; req_op = op; req_operandA = a; req_operandB = b; req_rd = rd;
    wb_ready  = 1'b0;

    for (int c = 1; c <= v + hold + 1; c++) begin
      @(negedge clock);
      if (c == 1) begin
        chk({nm, "_ctrl_MULT"}, ctrl_MULT, !div0 && !op);
        chk({nm, "_ctrl_DIV"}, ctrl_DIV, !div0 && op);
        chk({nm, "_md_operandB"}, md_operandB, b);
      end else begin
        chk({nm, "_no_pulse"}, {ctrl_MULT, ctrl_DIV}, 0);
      end
      chk({nm, "_md_operandA"}, md_operandA, a);
      chk({nm, "_wb_valid"}, wb_valid, (c >= v) && (c <= v + hold));
      if (c >= v && c <= v + hold) begin
        chk({nm, "_wb_result"}, wb_result, exp_res);
        chk({nm, "_wb_exception"}, wb_exception, exp_exc);
        chk({nm, "_wb_rd"}, wb_rd, rd);
        chk({nm, "_done_req_ready"}, req_ready, 0);
      end
      chk({nm, "_busy"}, busy, c <= v + hold);
      if (c == v + hold + 1) chk({nm, "_back_idle"}, req_ready, 1);

      // A competing request is offered while DONE, including the retire cycle.
      req_valid    = (c >= v) && (c <= v + hold);
      req_op       = 1'b0;
      req_operandA = ~a;
      req_operandB = ~b;
      req_rd       = ~rd;
      wb_ready     = (c == v + hold);
      drive_units(op, c, rdy_cyc, unit_res, exc_in);
    end
    req_valid = 1'b0;
    wb_ready  = 1'b0;
  endtask

  initial begin
    logic        rop, rexc;
    logic [31:0] ra, rb;
    reset = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_operandA = '0; req_operandB = '0;
    req_rd = '0; wb_ready = 1'b0;
    mult_result = '0; div_result = '0; mult_exception = 1'b0; div_exception = 1'b0;
    mult_resultRDY = 1'b0; div_resultRDY = 1'b0;

    repeat (3) @(negedge clock);
    chk("rst_ctrl", {ctrl_MULT, ctrl_DIV}, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_exception", wb_exception, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wb_result", wb_result, 0);
    chk("rst_md_operandA", md_operandA, 0);
    chk("rst_md_operandB", md_operandB, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_req_ready", req_ready, 0);
    reset = 1'b0;
    @(negedge clock);

    do_op(1'b1, 32'd100, 32'd7, 5'd9, 6, 1'b0, 0, "div100_7");
    do_op(1'b1, 32'd5, 32'd0, 5'd3, 4, 1'b0, 0, "div5_0");
    do_op(1'b0, -32'sd3, 32'd4, 5'd17, 18, 1'b0, 0, "mul_m3x4");
    do_op(1'b0, 32'd123, 32'd456, 5'd2, 0, 1'b0, 0, "timeout");
    do_op(1'b1, -32'sd1000, 32'd33, 5'd30, 2 + TIMEOUT, 1'b1, 0, "rdy_at_limit");
    do_op(1'b0, 32'd77, -32'sd5, 5'd8, 2, 1'b1, 5, "hold5");

    for (int i = 0; i < 8; i++) begin
      rop  = 1'($urandom_range(0, 1));
      ra   = $urandom;
      rb   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if (rb == 32'hFFFF_FFFF) rb = 32'd3;
      rexc = 1'($urandom_range(0, 1));
      do_op(rop, ra, rb, 5'($urandom), int'($urandom_range(2, 50)), rexc,
            int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
    end

    // Reset in the 10th WAIT cycle, then a late RDY from the abandoned unit.
    req_valid = 1'b1; req_op = 1'b0; req_operandA = 32'd11; req_operandB = 32'd12; req_rd = 5'd4;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clock);
      if (c >= 2 && c <= 11) chk("midrst_busy_before", busy, 1);
      if (c == 12) begin
        chk("midrst_ctrl", {ctrl_MULT, ctrl_DIV}, 0);
        chk("midrst_wb_result", wb_result, 0);
        chk("midrst_wb_exception", wb_exception, 0);
        chk("midrst_md_operandA", md_operandA, 0);
        chk("midrst_md_operandB", md_operandB, 0);
        chk("midrst_wb_rd", wb_rd, 0);
        chk("midrst_req_ready", req_ready, 0);
      end
      if (c >= 12) begin
        chk("midrst_wb_valid", wb_valid, 0);
        chk("midrst_busy", busy, 0);
      end
      if (c >= 13) chk("midrst_ready_after", req_ready, 1);
      req_valid      = 1'b0;
      reset          = (c == 11);
      mult_resultRDY = (c == 20);
      mult_result    = $urandom;
      mult_exception = 1'b1;
      div_resultRDY  = 1'b0;
    end
    mult_resultRDY = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
